// File: rtl/pipe_dest_tracker.sv
// Destination-register tracker for the EX-stage forwarding path: carries Rd/RegWrite through
// EX/MEM and MEM/WB, and drives load-use / memory-wait stall control with debug counters.
//
// state   | meaning
// ST_RUN  | pipeline advancing normally, or a load in MEM completing on its first cycle
// ST_WAIT | a load in MEM is waiting on data memory; EX/MEM is frozen
module pipe_dest_tracker #(
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] idex_rd,
  input  logic          idex_regwrite,
  input  logic          idex_memread,
  input  logic [RW-1:0] ifid_rs,
  input  logic [RW-1:0] ifid_rt,
  input  logic          ifid_uses_rt,
  input  logic          flush,
  input  logic          mem_ready,
  input  logic          cnt_clr,
  output logic [RW-1:0] exmem_rd,
  output logic          exmem_regwrite,
  output logic          exmem_memread,
  output logic [RW-1:0] memwb_rd,
  output logic          memwb_regwrite,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          idex_write,
  output logic          idex_bubble,
  output logic          mem_waiting,
  output logic [CW-1:0] lu_stall_cnt,
  output logic [CW-1:0] mem_stall_cnt
);

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t state, state_nxt;
  logic   mem_stall;
  logic   load_use;
  logic   lu_win;

  assign mem_stall = exmem_memread & ~mem_ready;
  assign load_use  = idex_memread & idex_regwrite & (idex_rd != '0) &
                     ((idex_rd == ifid_rs) | (ifid_uses_rt & (idex_rd == ifid_rt)));

  // Priority: memory wait freezes everything, then flush, then load-use.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    lu_win      = 1'b0;
    if (mem_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else if (flush) begin
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      lu_win      = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (mem_stall) state_nxt = ST_WAIT;
      ST_WAIT: if (mem_ready) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  assign mem_waiting = (state == ST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // While stalled, MEM/WB takes a bubble so a completed writeback is not replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_rd       <= '0;
      exmem_regwrite <= 1'b0;
      exmem_memread  <= 1'b0;
      memwb_rd       <= '0;
      memwb_regwrite <= 1'b0;
    end else if (mem_stall) begin
      memwb_rd       <= '0;
      memwb_regwrite <= 1'b0;
    end else begin
      exmem_rd       <= idex_rd;
      exmem_regwrite <= idex_regwrite;
      exmem_memread  <= idex_memread;
      memwb_rd       <= exmem_rd;
      memwb_regwrite <= exmem_regwrite;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt  <= '0;
      mem_stall_cnt <= '0;
    end else if (cnt_clr) begin
      lu_stall_cnt  <= '0;
      mem_stall_cnt <= '0;
    end else begin
      if (lu_win && !(&lu_stall_cnt)) begin
        lu_stall_cnt <= lu_stall_cnt + CW'(1);
      end
      if (mem_stall && !(&mem_stall_cnt)) begin
        mem_stall_cnt <= mem_stall_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Directed bench for pipe_dest_tracker: forwarding fields, stall control, counters and async reset.
module tb_pipe_dest_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  idex_rd, ifid_rs, ifid_rt;
  logic        idex_regwrite, idex_memread, ifid_uses_rt, flush, mem_ready, cnt_clr;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_regwrite, exmem_memread, memwb_regwrite;
  logic        pc_write, ifid_write, idex_write, idex_bubble, mem_waiting;
  logic [15:0] lu_stall_cnt, mem_stall_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_dest_tracker #(.RW(5), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .idex_rd(idex_rd), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .flush(flush), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .idex_bubble(idex_bubble), .mem_waiting(mem_waiting),
    .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idex(input logic [4:0] rd, input logic rw, input logic mr);
    idex_rd       = rd;
    idex_regwrite = rw;
    idex_memread  = mr;
  endtask

  initial begin
    rst_n = 1'b0;
    set_idex(5'd0, 1'b0, 1'b0);
    ifid_rs = '0; ifid_rt = '0; ifid_uses_rt = 1'b0;
    flush = 1'b0; mem_ready = 1'b1; cnt_clr = 1'b0;
    #2;
    check("rst_exmem_rd", exmem_rd, 0);
    check("rst_exmem_rw", exmem_regwrite, 0);
    check("rst_memwb_rd", memwb_rd, 0);
    check("rst_waiting", mem_waiting, 0);
    check("rst_lu_cnt", lu_stall_cnt, 0);
    check("rst_mem_cnt", mem_stall_cnt, 0);
    check("rst_pc_write", pc_write, 1);
    #10 rst_n = 1'b1;
    step();

    // Plain ALU writer flows EX/MEM -> MEM/WB
    set_idex(5'd5, 1'b1, 1'b0);
    step();
    check("fwd_exmem_rd", exmem_rd, 5);
    check("fwd_exmem_rw", exmem_regwrite, 1);
    check("fwd_exmem_mr", exmem_memread, 0);
    set_idex(5'd0, 1'b0, 1'b0);
    step();
    check("fwd_memwb_rd", memwb_rd, 5);
    check("fwd_memwb_rw", memwb_regwrite, 1);
    check("fwd_pc_write", pc_write, 1);
    check("fwd_bubble", idex_bubble, 0);

    // Load-use on Rs
    set_idex(5'd8, 1'b1, 1'b1);
    ifid_rs = 5'd8;
    #1;
    check("lu_pc_write", pc_write, 0);
    check("lu_ifid_write", ifid_write, 0);
    check("lu_idex_write", idex_write, 1);
    check("lu_bubble", idex_bubble, 1);
    step();
    check("lu_cnt_1", lu_stall_cnt, 1);
    set_idex(5'd0, 1'b0, 1'b0);
    #1;
    check("lu_one_cycle_pc", pc_write, 1);
    check("lu_one_cycle_bubble", idex_bubble, 0);

    // Rt match only counts when the instruction reads Rt
    set_idex(5'd8, 1'b1, 1'b1);
    ifid_rs = 5'd0; ifid_rt = 5'd8; ifid_uses_rt = 1'b0;
    #1;
    check("rt_unused_bubble", idex_bubble, 0);
    check("rt_unused_pc", pc_write, 1);
    ifid_uses_rt = 1'b1;
    #1;
    check("rt_used_bubble", idex_bubble, 1);
    ifid_uses_rt = 1'b0;
    ifid_rt = 5'd0;
    step();
    set_idex(5'd0, 1'b0, 1'b0);
    step();
    step();
    check("lu_cnt_still_1", lu_stall_cnt, 1);

    // Load waits three cycles in MEM
    set_idex(5'd9, 1'b1, 1'b1);
    step();
    check("ld_exmem_rd", exmem_rd, 9);
    set_idex(5'd0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #1;
    check("ms_pc_write", pc_write, 0);
    check("ms_idex_write", idex_write, 0);
    check("ms_bubble", idex_bubble, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("ms_waiting_%0d", i), mem_waiting, 1);
      check($sformatf("ms_exmem_rd_%0d", i), exmem_rd, 9);
      check($sformatf("ms_memwb_rw_%0d", i), memwb_regwrite, 0);
    end
    mem_ready = 1'b1;
    step();
    check("ms_resume_waiting", mem_waiting, 0);
    check("ms_resume_memwb_rd", memwb_rd, 9);
    check("ms_resume_memwb_rw", memwb_regwrite, 1);
    check("ms_cnt_3", mem_stall_cnt, 3);
    check("ms_exmem_next", exmem_rd, 0);

    // Flush beats load-use
    set_idex(5'd10, 1'b1, 1'b1);
    ifid_rs = 5'd10;
    flush = 1'b1;
    #1;
    check("fl_lu_bubble", idex_bubble, 1);
    check("fl_lu_pc_write", pc_write, 1);
    check("fl_lu_ifid_write", ifid_write, 1);
    step();
    check("fl_lu_cnt", lu_stall_cnt, 1);

    // Flush ignored while the load in MEM stalls
    set_idex(5'd0, 1'b0, 1'b0);
    ifid_rs = 5'd0;
    mem_ready = 1'b0;
    #1;
    check("fl_ms_pc_write", pc_write, 0);
    check("fl_ms_ifid_write", ifid_write, 0);
    check("fl_ms_idex_write", idex_write, 0);
    check("fl_ms_bubble", idex_bubble, 0);
    mem_ready = 1'b1;
    flush = 1'b0;
    step();

    // Saturate the memory-stall counter
    set_idex(5'd11, 1'b1, 1'b1);
    step();
    set_idex(5'd0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 65532; i++) step();
    check("sat_reach_max", mem_stall_cnt, 16'hFFFF);
    step();
    check("sat_hold_max", mem_stall_cnt, 16'hFFFF);
    cnt_clr = 1'b1;
    step();
    check("clr_mem_cnt", mem_stall_cnt, 0);
    check("clr_lu_cnt", lu_stall_cnt, 0);
    cnt_clr = 1'b0;
    step();
    check("after_clr_cnt", mem_stall_cnt, 1);
    check("after_clr_waiting", mem_waiting, 1);

    // Async reset mid-wait
    #3 rst_n = 1'b0;
    #1;
    check("arst_waiting", mem_waiting, 0);
    check("arst_exmem_rd", exmem_rd, 0);
    check("arst_exmem_mr", exmem_memread, 0);
    check("arst_memwb_rw", memwb_regwrite, 0);
    check("arst_mem_cnt", mem_stall_cnt, 0);
    check("arst_pc_write", pc_write, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
